// File: rtl/fma_mprod_norm.sv
// FMA product normaliser: sideband delay line matched to the multiplier,
// 106->53 bit normalisation and round-to-nearest-even, valid-tagged output.
module fma_mprod_norm #(
  parameter int MULT_LAT = 2,
  parameter int EXP_W    = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_zero,
  input  logic [105:0]     p,
  output logic             out_valid,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [52:0]      out_mant,
  output logic             out_inexact,
  output logic             out_zero
);

  localparam int SB_W = EXP_W + 3;

  logic [SB_W-1:0] sb_in;
  logic [SB_W-1:0] sb_al;

  assign sb_in = {in_valid, in_sign, in_exp, in_zero};

  generate
    if (MULT_LAT == 0) begin : g_nodly
      assign sb_al = sb_in;
    end else begin : g_dly
      logic [MULT_LAT-1:0][SB_W-1:0] dq;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dq <= '0;
        end else if (ce) begin
          dq[0] <= sb_in;
          for (int i = 1; i < MULT_LAT; i++)
            dq[i] <= dq[i-1];
        end
      end

      assign sb_al = dq[MULT_LAT-1];
    end
  endgenerate

  logic             a_valid;
  logic             a_sign;
  logic [EXP_W-1:0] a_exp;
  logic             a_zero;

  assign a_valid = sb_al[SB_W-1];
  assign a_sign  = sb_al[SB_W-2];
  assign a_exp   = sb_al[SB_W-3:1];
  assign a_zero  = sb_al[0];

  // a clear top bit means the leading one sits at [104]
  logic             hi;
  logic [52:0]      nm;
  logic             ng;
  logic             ns;
  logic [EXP_W-1:0] ne;

  assign hi = p[105];
  assign nm = hi ? p[105:53] : p[104:52];
  assign ng = hi ? p[52] : p[51];
  assign ns = hi ? |p[51:0] : |p[50:0];
  assign ne = a_exp + EXP_W'(hi);

  logic             n1_valid;
  logic             n1_sign;
  logic             n1_zero;
  logic [52:0]      n1_m;
  logic             n1_g;
  logic             n1_s;
  logic [EXP_W-1:0] n1_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n1_valid <= 1'b0;
      n1_sign  <= 1'b0;
      n1_zero  <= 1'b0;
      n1_m     <= '0;
      n1_g     <= 1'b0;
      n1_s     <= 1'b0;
      n1_e     <= '0;
    end else if (ce) begin
      n1_valid <= a_valid;
      n1_sign  <= a_sign;
      n1_zero  <= a_zero;
      n1_m     <= nm;
      n1_g     <= ng;
      n1_s     <= ns;
      n1_e     <= ne;
    end
  end

  logic             rnd;
  logic [53:0]      sum;
  logic             cy;
  logic [52:0]      rm;
  logic [EXP_W-1:0] re;

  assign rnd = n1_g & (n1_s | n1_m[0]);
  assign sum = {1'b0, n1_m} + 54'(rnd);
  assign cy  = sum[53];
  assign rm  = cy ? {1'b1, 52'b0} : sum[52:0];
  assign re  = n1_e + EXP_W'(cy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_exp     <= '0;
      out_mant    <= '0;
      out_inexact <= 1'b0;
      out_zero    <= 1'b0;
    end else if (ce) begin
      out_valid   <= n1_valid;
      out_sign    <= n1_sign;
      out_zero    <= n1_zero;
      out_exp     <= n1_zero ? '0 : re;
      out_mant    <= n1_zero ? '0 : rm;
      out_inexact <= n1_zero ? 1'b0 : (n1_g | n1_s);
    end
  end

endmodule

// File: tb/tb_fma_mprod_norm.sv
// Scoreboard bench for fma_mprod_norm: directed corner cases, random
// streams with ce gating and a mid-stream reset, against an arithmetic model.
module tb_fma_mprod_norm;

  localparam int ML    = 2;
  localparam int EXP_W = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic             ce;
  logic             in_valid;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic             in_zero;
  logic [105:0]     p;
  logic             out_valid;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [52:0]      out_mant;
  logic             out_inexact;
  logic             out_zero;

  fma_mprod_norm #(.MULT_LAT(ML), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .in_valid(in_valid), .in_sign(in_sign),
    .in_exp(in_exp), .in_zero(in_zero), .p(p),
    .out_valid(out_valid), .out_sign(out_sign),
    .out_exp(out_exp), .out_mant(out_mant),
    .out_inexact(out_inexact), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               v;
    bit               s;
    logic [EXP_W-1:0] e;
    logic [52:0]      m;
    bit               x;
    bit               z;
  } exp_t;

  exp_t         sq[$];
  logic [105:0] hp[$];
  exp_t         last_e;
  exp_t         nul;
  int           ncmp = 0;
  int           nerr = 0;

  // product value rounded to 53 significant bits, ties to even
  function automatic exp_t model(bit v, bit s, logic [EXP_W-1:0] e,
                                 bit z, logic [105:0] pv);
    exp_t         r;
    int           sh;
    logic [105:0] m, rem, half;
    r.v = v; r.s = s; r.z = z;
    r.e = '0; r.m = '0; r.x = 1'b0;
    if (z) return r;
    sh   = pv[105] ? 53 : 52;
    m    = pv >> sh;
    rem  = pv - (m << sh);
    half = 106'(1) << (sh - 1);
    r.x  = (rem != 0);
    r.e  = e + EXP_W'(sh - 52);
    if (rem > half || (rem == half && m[0])) m = m + 1;
    if (m == (106'(1) << 53)) begin
      m   = m >> 1;
      r.e = r.e + 1;
    end
    r.m = m[52:0];
    return r;
  endfunction

  task automatic check(input exp_t x, input string tag);
    ncmp++;
    if (out_valid !== x.v) begin
      nerr++;
      $display("FAIL %s valid: got %b want %b", tag, out_valid, x.v);
    end else if (x.v &&
        {out_sign, out_exp, out_mant, out_inexact, out_zero} !==
        {x.s, x.e, x.m, x.x, x.z}) begin
      nerr++;
      $display("FAIL %s data: got s%b e%h m%h x%b z%b want s%b e%h m%h x%b z%b",
               tag, out_sign, out_exp, out_mant, out_inexact, out_zero,
               x.s, x.e, x.m, x.x, x.z);
    end
  endtask

  task automatic check_clear(input string tag);
    ncmp++;
    if ({out_valid, out_sign, out_exp, out_mant, out_inexact, out_zero} !== '0) begin
      nerr++;
      $display("FAIL %s: got v%b s%b e%h m%h x%b z%b want all zero", tag,
               out_valid, out_sign, out_exp, out_mant, out_inexact, out_zero);
    end
  endtask

  task automatic prefill();
    sq.delete();
    for (int i = 0; i < ML + 1; i++) sq.push_back(nul);
    last_e = nul;
  endtask

  task automatic step(input bit cev, input bit v, input bit s,
                      input logic [EXP_W-1:0] e, input bit z,
                      input logic [105:0] pv);
    logic [127:0] r;
    @(negedge clk);
    ce = cev;
    if (cev) begin
      in_valid = v; in_sign = s; in_exp = e; in_zero = z;
      hp.push_back(pv);
      if (hp.size() > ML + 1) void'(hp.pop_front());
      r = {$urandom, $urandom, $urandom, $urandom};
      p = (hp.size() == ML + 1) ? hp[0] : r[105:0];
      sq.push_back(model(v, s, e, z, pv));
    end
  endtask

  task automatic rnd_step(input bit cev);
    logic [127:0]     r;
    logic [105:0]     pv;
    bit               v, s, z;
    logic [EXP_W-1:0] e;
    int               k;
    r  = {$urandom, $urandom, $urandom, $urandom};
    pv = r[105:0];
    v  = ($urandom_range(0, 3) != 0);
    s  = $urandom_range(0, 1);
    e  = EXP_W'($urandom);
    z  = ($urandom_range(0, 9) == 0);
    if (!z) begin
      if ($urandom_range(0, 1) == 1) pv[105] = 1'b1;
      else begin pv[105] = 1'b0; pv[104] = 1'b1; end
      k = $urandom_range(0, 5);
      if (k == 0) begin
        if (pv[105]) begin pv[52] = 1'b1; pv[51:0] = '0; end
        else begin pv[51] = 1'b1; pv[50:0] = '0; end
      end else if (k == 1) begin
        pv[103:0] = '1;
      end
    end
    step(cev, v, s, e, z, pv);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; ce = 1'b0;
    #1 check_clear("async_rst");
    @(negedge clk);
    check_clear("rst_hold");
    prefill();
    rst = 1'b0;
  endtask

  initial begin : monitor
    bit ce_at, r_at;
    exp_t x;
    forever begin
      @(posedge clk);
      ce_at = ce; r_at = rst;
      #1;
      if (!r_at && !rst) begin
        if (ce_at) begin
          if (sq.size() == 0) begin
            ncmp++; nerr++;
            $display("FAIL sb_underflow: got empty queue want entry");
          end else begin
            x = sq.pop_front();
            check(x, "result");
            last_e = x;
          end
        end else begin
          check(last_e, "hold");
        end
      end
    end
  end

  initial begin
    nul = '{v: 1'b0, s: 1'b0, e: '0, m: '0, x: 1'b0, z: 1'b0};
    rst = 1'b1; ce = 1'b0; in_valid = 1'b0; in_sign = 1'b0;
    in_exp = '0; in_zero = 1'b0; p = '0;
    prefill();
    #1 check_clear("reset_state");
    repeat (3) @(negedge clk);
    check_clear("reset_state_ce0");
    rst = 1'b0;

    step(1, 1, 0, 13'd0, 0, 106'(1) << 104);
    step(1, 1, 0, 13'd3, 0, 106'(9) << 102);
    step(1, 1, 1, 13'd7, 0, (106'(1) << 104) | (106'(1) << 51));
    step(1, 1, 0, 13'd7, 0, (106'(1) << 104) | (106'(3) << 51));
    step(1, 1, 0, 13'd0 - 13'd5, 0, {1'b0, {105{1'b1}}});
    step(1, 1, 1, 13'd99, 1, {$urandom, $urandom, $urandom, 10'h2a5});
    step(1, 0, 0, 13'd0, 0, 106'(1) << 105);
    step(1, 1, 0, 13'h1fff, 0, 106'(1) << 105);

    for (int i = 0; i < 60; i++) rnd_step(1'b1);
    for (int i = 0; i < 40; i++) rnd_step(i % 2 == 0);
    pulse_rst();
    for (int i = 0; i < 40; i++) rnd_step(i % 2 == 0);
    for (int i = 0; i < 150; i++) rnd_step($urandom_range(0, 2) != 0);
    for (int i = 0; i < ML + 3; i++) step(1, 0, 0, '0, 0, '0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
